// File: rtl/uart_icb_streamer.sv
// ICB master: programs the UART, polls CSR every POLL_GAP cycles, streams TX FIFO bytes out and RX bytes in.
// One access in flight; TX stalls via tx_byte_ready when the FIFO is full, RX holds until rx_byte_ready.
module uart_icb_streamer #(
  parameter int              PA_W       = 32,
  parameter logic [PA_W-1:0] BASE_ADDR  = 32'h1001_3000,
  parameter logic [PA_W-1:0] CSR_OFS    = 32'h00,
  parameter logic [PA_W-1:0] CTRL_OFS   = 32'h04,
  parameter logic [PA_W-1:0] DATA_OFS   = 32'h08,
  parameter int              FIFO_DEPTH = 4,
  parameter int              POLL_GAP   = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cfg_start,
  input  logic            cfg_stop,
  input  logic [15:0]     cfg_divisor,
  input  logic            cfg_no_parity,
  input  logic            cfg_ev_parity,
  input  logic            tx_byte_valid,
  output logic            tx_byte_ready,
  input  logic [7:0]      tx_byte_data,
  output logic            rx_byte_valid,
  input  logic            rx_byte_ready,
  output logic [7:0]      rx_byte_data,
  output logic            o_icb_cmd_valid,
  input  logic            o_icb_cmd_ready,
  output logic [PA_W-1:0] o_icb_cmd_addr,
  output logic            o_icb_cmd_read,
  output logic [PA_W-1:0] o_icb_cmd_wdata,
  input  logic            o_icb_rsp_valid,
  output logic            o_icb_rsp_ready,
  input  logic [PA_W-1:0] o_icb_rsp_rdata,
  output logic            busy,
  output logic            running,
  output logic            parity_err
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam logic [CNT_W-1:0] FIFO_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(POLL_GAP - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_CFG_CSR, S_CFG_CTRL, S_WAIT, S_POLL, S_TX_WR, S_RX_RD, S_CTRL_RD, S_STOP_WR
  } state_t;

  state_t           state, nxt;
  logic [GAP_W-1:0] gap_cnt;
  logic             stop_pend, no_par_q, ev_par_q;
  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] fifo_cnt;
  logic             push, pop, cmd_hs, rsp_hs, stop_now;
  logic [PA_W-1:0]  nxt_addr, nxt_wdata;
  logic             nxt_read;
  logic [31:0]      ctrl_word;
  logic             unused_rdata;

  assign cmd_hs        = o_icb_cmd_valid & o_icb_cmd_ready;
  assign rsp_hs        = o_icb_rsp_ready & o_icb_rsp_valid;
  assign stop_now      = stop_pend | cfg_stop;
  assign tx_byte_ready = (fifo_cnt != FIFO_FULL);
  assign push          = tx_byte_valid & tx_byte_ready;
  assign pop           = (state == S_TX_WR) & cmd_hs;
  assign busy          = (state != S_IDLE);
  assign ctrl_word     = 32'h0000_0111 | (32'(no_par_q) << 12) | (32'(ev_par_q) << 16);
  assign unused_rdata  = ^o_icb_rsp_rdata;

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE: if (cfg_start) nxt = S_CFG_CSR;
      S_WAIT: begin
        if (stop_now) nxt = S_STOP_WR;
        else if (gap_cnt == GAP_LAST) nxt = S_POLL;
      end
      default: if (rsp_hs) begin
        if (state == S_STOP_WR) nxt = S_IDLE;
        else if (stop_now) nxt = S_STOP_WR;
        else begin
          case (state)
            S_CFG_CSR: nxt = S_CFG_CTRL;
            S_RX_RD:   nxt = S_CTRL_RD;
            // RX first so the UART receive register never overruns
            S_POLL: begin
              if (o_icb_rsp_rdata[4] && !rx_byte_valid) nxt = S_RX_RD;
              else if (o_icb_rsp_rdata[0] && (fifo_cnt != '0)) nxt = S_TX_WR;
              else nxt = S_WAIT;
            end
            default:   nxt = S_WAIT;
          endcase
        end
      end
    endcase
  end

  // CFG_CSR is only entered from IDLE, so the divisor comes straight from the input being latched
  always_comb begin
    nxt_addr  = BASE_ADDR + CSR_OFS;
    nxt_read  = 1'b0;
    nxt_wdata = '0;
    case (nxt)
      S_CFG_CSR:  nxt_wdata = PA_W'({cfg_divisor, 16'h0});
      S_CFG_CTRL: begin nxt_addr = BASE_ADDR + CTRL_OFS; nxt_wdata = PA_W'(ctrl_word); end
      S_POLL:     nxt_read = 1'b1;
      S_TX_WR:    begin nxt_addr = BASE_ADDR + DATA_OFS; nxt_wdata = PA_W'(fifo_mem[rd_ptr]); end
      S_RX_RD:    begin nxt_addr = BASE_ADDR + DATA_OFS; nxt_read = 1'b1; end
      S_CTRL_RD:  begin nxt_addr = BASE_ADDR + CTRL_OFS; nxt_read = 1'b1; end
      S_STOP_WR:  nxt_addr = BASE_ADDR + CTRL_OFS;
      default:    ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      gap_cnt         <= '0;
      stop_pend       <= 1'b0;
      no_par_q        <= 1'b0;
      ev_par_q        <= 1'b0;
      o_icb_cmd_valid <= 1'b0;
      o_icb_cmd_addr  <= '0;
      o_icb_cmd_read  <= 1'b0;
      o_icb_cmd_wdata <= '0;
      o_icb_rsp_ready <= 1'b0;
      running         <= 1'b0;
      parity_err      <= 1'b0;
      rx_byte_valid   <= 1'b0;
      rx_byte_data    <= '0;
    end else begin
      state   <= nxt;
      gap_cnt <= (state == S_WAIT && nxt == S_WAIT) ? gap_cnt + 1'b1 : '0;
      if (nxt != state && nxt != S_IDLE && nxt != S_WAIT) begin
        o_icb_cmd_valid <= 1'b1;
        o_icb_cmd_addr  <= nxt_addr;
        o_icb_cmd_read  <= nxt_read;
        o_icb_cmd_wdata <= nxt_wdata;
      end else if (cmd_hs) begin
        o_icb_cmd_valid <= 1'b0;
      end
      if (cmd_hs) o_icb_rsp_ready <= 1'b1;
      else if (rsp_hs) o_icb_rsp_ready <= 1'b0;
      if (state == S_IDLE && cfg_start) begin
        no_par_q   <= cfg_no_parity;
        ev_par_q   <= cfg_ev_parity;
        parity_err <= 1'b0;
      end else if (state == S_CTRL_RD && rsp_hs && o_icb_rsp_rdata[20]) begin
        parity_err <= 1'b1;
      end
      if (nxt == S_IDLE || nxt == S_STOP_WR) stop_pend <= 1'b0;
      else if (cfg_stop && state != S_IDLE) stop_pend <= 1'b1;
      if (nxt == S_IDLE) running <= 1'b0;
      else if (state == S_CFG_CTRL && rsp_hs) running <= 1'b1;
      if (state == S_RX_RD && rsp_hs) begin
        rx_byte_valid <= 1'b1;
        rx_byte_data  <= o_icb_rsp_rdata[7:0];
      end else if (rx_byte_valid && rx_byte_ready) begin
        rx_byte_valid <= 1'b0;
      end
    end
  end

  // Full-count ready means push and pop never collide on a full FIFO; pointers wrap at the power-of-2 depth
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      fifo_cnt <= fifo_cnt + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= tx_byte_data;
  end
endmodule

// File: tb/tb_uart_icb_streamer.sv
// Bench for uart_icb_streamer: the bench plays the UART ICB slave and predicts every access from a byte-queue model.
module tb_uart_icb_streamer;
  localparam logic [31:0] A_CSR  = 32'h1001_3000;
  localparam logic [31:0] A_CTRL = 32'h1001_3004;
  localparam logic [31:0] A_DATA = 32'h1001_3008;

  logic        clk, rst_n;
  logic        cfg_start, cfg_stop, cfg_no_parity, cfg_ev_parity;
  logic [15:0] cfg_divisor;
  logic        tx_byte_valid, tx_byte_ready;
  logic [7:0]  tx_byte_data;
  logic        rx_byte_valid, rx_byte_ready;
  logic [7:0]  rx_byte_data;
  logic        o_icb_cmd_valid, o_icb_cmd_ready, o_icb_cmd_read;
  logic [31:0] o_icb_cmd_addr, o_icb_cmd_wdata;
  logic        o_icb_rsp_valid, o_icb_rsp_ready;
  logic [31:0] o_icb_rsp_rdata;
  logic        busy, running, parity_err;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] q[$];
  bit         rx_held;
  logic [7:0] rx_exp;
  bit         pe_model;

  uart_icb_streamer dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_start(cfg_start), .cfg_stop(cfg_stop), .cfg_divisor(cfg_divisor),
    .cfg_no_parity(cfg_no_parity), .cfg_ev_parity(cfg_ev_parity),
    .tx_byte_valid(tx_byte_valid), .tx_byte_ready(tx_byte_ready), .tx_byte_data(tx_byte_data),
    .rx_byte_valid(rx_byte_valid), .rx_byte_ready(rx_byte_ready), .rx_byte_data(rx_byte_data),
    .o_icb_cmd_valid(o_icb_cmd_valid), .o_icb_cmd_ready(o_icb_cmd_ready),
    .o_icb_cmd_addr(o_icb_cmd_addr), .o_icb_cmd_read(o_icb_cmd_read),
    .o_icb_cmd_wdata(o_icb_cmd_wdata), .o_icb_rsp_valid(o_icb_rsp_valid),
    .o_icb_rsp_ready(o_icb_rsp_ready), .o_icb_rsp_rdata(o_icb_rsp_rdata),
    .busy(busy), .running(running), .parity_err(parity_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge; a TX byte offered while ready is recorded as accepted by the FIFO.
  task automatic tick();
    bit acc;
    acc = tx_byte_valid && tx_byte_ready;
    if (acc) q.push_back(tx_byte_data);
    @(negedge clk);
    if (acc) tx_byte_valid = 1'b0;
  endtask

  task automatic push(input logic [7:0] b);
    int n;
    n = 0;
    tx_byte_valid = 1'b1;
    tx_byte_data  = b;
    while (tx_byte_valid && n < 50) begin tick(); n++; end
    chk("push_accepted", tx_byte_valid, 0);
    tx_byte_valid = 1'b0;
  endtask

  task automatic consume();
    chk("rx_valid_held", rx_byte_valid, 1);
    chk("rx_data_held", rx_byte_data, rx_exp);
    rx_byte_ready = 1'b1;
    tick();
    rx_byte_ready = 1'b0;
    chk("rx_valid_drop", rx_byte_valid, 0);
    rx_held = 1'b0;
  endtask

  // Slave side of one ICB access: wait for the command, check it, stall, accept, respond.
  task automatic serve(input string tag, input bit exp_rd, input logic [31:0] exp_addr,
                       input logic [31:0] exp_wd, input logic [31:0] rdata,
                       input int stall, input bit stop_mid);
    int n;
    n = 0;
    while (!o_icb_cmd_valid && n < 100) begin tick(); n++; end
    chk({tag, "_cmd_seen"}, o_icb_cmd_valid, 1);
    if (!o_icb_cmd_valid) return;
    chk({tag, "_rsp_rdy_in_cmd"}, o_icb_rsp_ready, 0);
    chk({tag, "_addr"}, o_icb_cmd_addr, exp_addr);
    chk({tag, "_read"}, o_icb_cmd_read, exp_rd);
    if (!exp_rd) chk({tag, "_wdata"}, o_icb_cmd_wdata, exp_wd);
    for (int i = 0; i < stall; i++) begin
      if (stop_mid && i == 0) cfg_stop = 1'b1;
      tick();
      cfg_stop = 1'b0;
      chk({tag, "_stall_valid"}, o_icb_cmd_valid, 1);
      chk({tag, "_stall_addr"}, o_icb_cmd_addr, exp_addr);
      chk({tag, "_stall_read"}, o_icb_cmd_read, exp_rd);
    end
    o_icb_cmd_ready = 1'b1;
    tick();
    o_icb_cmd_ready = 1'b0;
    chk({tag, "_cmd_drop"}, o_icb_cmd_valid, 0);
    n = $urandom_range(0, 3);
    for (int i = 0; i < n; i++) begin
      chk({tag, "_rsp_rdy"}, o_icb_rsp_ready, 1);
      tick();
    end
    chk({tag, "_rsp_rdy"}, o_icb_rsp_ready, 1);
    o_icb_rsp_valid = 1'b1;
    o_icb_rsp_rdata = rdata;
    tick();
    o_icb_rsp_valid = 1'b0;
    o_icb_rsp_rdata = $urandom;
    chk({tag, "_rsp_rdy_drop"}, o_icb_rsp_ready, 0);
  endtask

  task automatic configure(input logic [15:0] div, input bit np, input bit ep);
    cfg_divisor = div; cfg_no_parity = np; cfg_ev_parity = ep;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    cfg_divisor = 16'($urandom); cfg_no_parity = ~np; cfg_ev_parity = ~ep;
    pe_model = 1'b0;
    chk("cfg_busy", busy, 1);
    chk("cfg_parity_clr", parity_err, 0);
    serve("cfg_csr", 0, A_CSR, {div, 16'h0}, $urandom, $urandom_range(0, 2), 0);
    serve("cfg_ctrl", 0, A_CTRL, 32'h111 | (32'(np) << 12) | (32'(ep) << 16), $urandom,
          $urandom_range(0, 2), 0);
    chk("cfg_running", running, 1);
  endtask

  // One poll and whatever access the UART status calls for, predicted from the queue and holding-register model.
  task automatic step(input logic [31:0] csr, input logic [31:0] drd, input logic [31:0] crd,
                      input int stall, input bit stop);
    serve("poll", 1, A_CSR, 0, csr, stall, stop);
    if (stop) begin
      serve("stop_wr", 0, A_CTRL, 0, $urandom, 0, 0);
      chk("stop_busy", busy, 0);
      chk("stop_running", running, 0);
      return;
    end
    if (csr[4] && !rx_held) begin
      serve("rx_rd", 1, A_DATA, 0, drd, $urandom_range(0, 2), 0);
      rx_held = 1'b1;
      rx_exp  = drd[7:0];
      chk("rx_valid", rx_byte_valid, 1);
      chk("rx_data", rx_byte_data, rx_exp);
      serve("ctrl_rd", 1, A_CTRL, 0, crd, $urandom_range(0, 2), 0);
      pe_model = pe_model | crd[20];
      chk("parity_err", parity_err, pe_model);
    end else if (csr[0] && q.size() != 0) begin
      serve("tx_wr", 0, A_DATA, {24'h0, q[0]}, $urandom, $urandom_range(0, 2), 0);
      void'(q.pop_front());
    end
  endtask

  initial begin
    logic [31:0] c;
    int n;
    rst_n = 1'b0; cfg_start = 0; cfg_stop = 0; cfg_divisor = 0; cfg_no_parity = 0; cfg_ev_parity = 0;
    tx_byte_valid = 0; tx_byte_data = 0; rx_byte_ready = 0;
    o_icb_cmd_ready = 0; o_icb_rsp_valid = 0; o_icb_rsp_rdata = 0;
    rx_held = 0; rx_exp = 0; pe_model = 0;
    repeat (3) @(negedge clk);
    chk("rst_cmd_valid", o_icb_cmd_valid, 0);
    chk("rst_rsp_ready", o_icb_rsp_ready, 0);
    chk("rst_tx_ready", tx_byte_ready, 1);
    chk("rst_rx_valid", rx_byte_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_running", running, 0);
    chk("rst_parity", parity_err, 0);
    rst_n = 1'b1;
    tick();

    // configure and two TX bytes
    configure(16'h0036, 1, 0);
    push(8'hA5);
    push(8'h3C);
    step(32'h1, 0, 0, 0, 0);
    step(32'h1, 0, 0, 1, 0);
    chk("fifo_drained", q.size(), 0);
    step(32'h1, 0, 0, 0, 0);

    // TX backpressure: fifth byte waits for the first TX write handshake
    for (int i = 0; i < 4; i++) push(8'($urandom));
    chk("bp_full", tx_byte_ready, 0);
    tx_byte_valid = 1'b1;
    tx_byte_data  = 8'($urandom);
    step(32'h0, 0, 0, 0, 0);
    chk("bp_still_full", tx_byte_ready, 0);
    chk("bp_fifth_pending", tx_byte_valid, 1);
    step(32'h1, 0, 0, 0, 0);
    chk("bp_fifth_taken", tx_byte_valid, 0);
    chk("bp_full_again", tx_byte_ready, 0);
    tx_byte_valid = 1'b0;

    // RX priority, hold while unconsumed, then parity
    step(32'h11, 32'hFFFF_FF5A, 32'h0, 0, 0);
    step(32'h10, 0, 0, 0, 0);
    step(32'h11, 0, 0, 0, 0);
    consume();
    step(32'h10, 32'h0000_0033, 32'h0010_0000, 0, 0);
    step(32'h0, 0, 0, 0, 0);
    chk("parity_sticky", parity_err, 1);
    consume();

    // stop requested while a poll command is stalled
    step(32'h0, 0, 0, 5, 1);
    configure(16'($urandom), 1'($urandom), 1'($urandom));

    // start while busy is ignored
    step(32'h0, 0, 0, 0, 0);
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    chk("start_ignored_busy", busy, 1);
    step(32'h0, 0, 0, 0, 0);

    // randomized traffic
    for (int it = 0; it < 60; it++) begin
      if (q.size() < 4 && $urandom_range(0, 1) == 1) push(8'($urandom));
      if (rx_held && $urandom_range(0, 2) == 0) consume();
      c = $urandom & 32'hFFFF_FFEF;
      c[4] = ($urandom_range(0, 2) == 0);
      step(c, $urandom, ($urandom & 32'hFFEF_FFFF) | (32'($urandom_range(0, 7) == 0) << 20),
           $urandom_range(0, 2), 0);
    end
    if (rx_held) consume();

    // stop from WAIT keeps FIFO contents
    if (q.size() < 4) push(8'($urandom));
    step(32'h0, 0, 0, 0, 0);
    cfg_stop = 1'b1;
    tick();
    cfg_stop = 1'b0;
    serve("stop_wait", 0, A_CTRL, 0, $urandom, 0, 0);
    chk("stop_wait_busy", busy, 0);
    chk("stop_wait_running", running, 0);
    configure(16'($urandom), 1'($urandom), 1'($urandom));
    n = 0;
    while (q.size() != 0 && n < 8) begin step(32'h1, 0, 0, 0, 0); n++; end
    chk("retained_drained", q.size(), 0);

    // asynchronous reset in the middle of a response phase
    step(32'h10, 32'h0000_00A7, 32'h0010_0000, 0, 0);
    n = 0;
    while (!o_icb_cmd_valid && n < 100) begin tick(); n++; end
    chk("rst_mid_cmd_seen", o_icb_cmd_valid, 1);
    o_icb_cmd_ready = 1'b1;
    tick();
    o_icb_cmd_ready = 1'b0;
    chk("rst_mid_in_rsp", o_icb_rsp_ready, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_cmd_valid", o_icb_cmd_valid, 0);
    chk("arst_cmd_addr", o_icb_cmd_addr, 0);
    chk("arst_cmd_wdata", o_icb_cmd_wdata, 0);
    chk("arst_cmd_read", o_icb_cmd_read, 0);
    chk("arst_rsp_ready", o_icb_rsp_ready, 0);
    chk("arst_tx_ready", tx_byte_ready, 1);
    chk("arst_rx_valid", rx_byte_valid, 0);
    chk("arst_rx_data", rx_byte_data, 0);
    chk("arst_busy", busy, 0);
    chk("arst_running", running, 0);
    chk("arst_parity", parity_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    q.delete();
    rx_held = 0;
    pe_model = 0;
    tick();
    chk("post_rst_busy", busy, 0);
    configure(16'h0101, 0, 1);
    push(8'h96);
    step(32'h1, 0, 0, 0, 0);
    chk("post_rst_drained", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
